ps2_host_tx: RTL and testbench
==============================

# ps2_host_tx

PS/2 host-to-device transmitter. It sends one command byte per request to the keyboard over the shared PS2_CLK/PS2_DAT open-drain lines, for example 0xED to set the LEDs, 0xF4 to enable scanning, or 0xFF to reset. It is the outbound counterpart of the keyboard listener and sits beside it at the top level. Its `rx_inhibit` output tells the listener to ignore line activity while a transmission is in progress.

## Interface
Parameters:
- `INHIBIT_CYCLES`, 6000: clock-low inhibit time before the start bit (120 µs at 50 MHz).
- `START_TIMEOUT_CYCLES`, 750000: maximum time from clock release to the first device falling edge (15 ms).
- `XFER_TIMEOUT_CYCLES`, 100000: maximum time from the first falling edge until the lines return to idle (2 ms).
- `FILTER_CYCLES`, 4: number of consecutive equal synchronized samples required before a line level is accepted.

Ports:
- `CLOCK_50` in 1: the single clock.
- `reset` in 1: asynchronous, active-high.
- `cmd_data` in 8: command byte to send.
- `cmd_valid` in 1: request; the command is accepted on a cycle where `cmd_valid & cmd_ready`.
- `cmd_ready` out 1: high only in IDLE.
- `ps2_clk_in`, `ps2_dat_in` in 1 each: raw pin levels.
- `ps2_clk_oe`, `ps2_dat_oe` out 1 each: 1 = drive the pin low, 0 = release it. The top level converts these to tri-states.
- `done` out 1: one-cycle pulse on a successful ACK.
- `error` out 1: one-cycle pulse on failure.
- `err_code` out 2: 0 none, 1 start timeout, 2 transfer timeout, 3 no ACK. Held until the next command is accepted.
- `rx_inhibit` out 1: high whenever the state is not IDLE.

## Operation
- Both pins pass through a 2-FF synchronizer and then the filter. A falling edge is the filtered level going 1 to 0.
- On accept:
  - Latch `cmd_data`.
  - Compute parity = ~^data (odd parity).
  - Load a 10-bit shift register with {1 (stop), parity, data}, sent LSB first.
  - Clear `err_code`.
- States and transitions:
  - **IDLE:** all oe = 0. Go to INHIBIT on accept.
  - **INHIBIT:** `ps2_clk_oe` = 1. When the counter reaches INHIBIT_CYCLES-1, set `ps2_dat_oe` = 1 (start bit) and go to RELEASE.
  - **RELEASE:** one cycle. Set `ps2_clk_oe` = 0, clear the timer, go to WAIT_FIRST.
  - **WAIT_FIRST:** on a falling edge, drive bit 0 (`ps2_dat_oe` = ~shift[0]), shift, set bit_cnt = 1, restart the timer, go to SEND. If the timer reaches START_TIMEOUT_CYCLES first, fail with code 1.
  - **SEND:** on each falling edge, drive the next bit and increment bit_cnt. The edge that places the stop bit (bit_cnt becomes 10) releases data and goes to ACK.
  - **ACK:** on the next falling edge, sample the filtered data line. 0 goes to WAIT_IDLE; 1 fails with code 3.
  - **WAIT_IDLE:** when the filtered clock and data are both 1, pulse `done` and go to IDLE.
- One timer is shared by WAIT_FIRST and SEND/ACK/WAIT_IDLE:
  - It is sized by $clog2 of the larger timeout and saturates, so it never wraps.
  - In SEND, ACK and WAIT_IDLE, reaching XFER_TIMEOUT_CYCLES fails with code 2.
- Failure action: both oe = 0, pulse `error`, set `err_code`, return to IDLE.
- `cmd_valid` outside IDLE is ignored and not queued.
- If a falling edge and a timeout expire in the same cycle, the timeout wins.

## Timing
- Reset values:
  - `ps2_clk_oe`, `ps2_dat_oe`, `done`, `error`, `rx_inhibit` = 0.
  - `err_code` = 0.
  - `cmd_ready` = 1.
  - State = IDLE.
- Reset asserted mid-transfer releases both lines asynchronously. No `done` or `error` pulse is produced.
- With accept on cycle T:
  - `ps2_clk_oe` rises at T+1; `cmd_ready` and `rx_inhibit` change at T+1.
  - `ps2_dat_oe` rises at T+INHIBIT_CYCLES.
  - `ps2_clk_oe` falls at T+INHIBIT_CYCLES+1.
- Pin-to-response latency: `ps2_dat_oe` updates 2+FILTER_CYCLES+1 cycles after the raw pin falls. This is well inside the device's clock-low half-period (≥30 µs).
- All outputs are registered. `done` and `error` are never high together.
- The next accept is possible on the cycle after the `done`/`error` pulse.

## Structure
- Package `ps2_pkg` holds:
  - the state enum;
  - err_code constants (ERR_NONE, ERR_START, ERR_XFER, ERR_NOACK);
  - default timing constants.
- Sub-module `ps2_line_filter` (synchronizer, filter, falling-edge pulse) is instantiated twice, once for clock and once for data.
- FSM, shift register, bit counter and timer live in the top of the block.

## Test plan
All scenarios use a device BFM with parameters INHIBIT=20, START=200, XFER=400, FILTER=2.
- Send 0xED; the BFM clocks 11 edges and ACKs. Expect:
  - `ps2_dat_oe` sequence start 1;
  - data bits (as oe) 0,1,0,0,1,0,0,0;
  - parity bit 1 (oe 0);
  - stop released;
  - `done` once, `err_code` = 0.
- Send 0xF4. Expect parity 0 (oe 1) and `done`.
- BFM never clocks. Expect `error` 200 cycles after clock release, `err_code` = 1, both oe = 0.
- BFM stops after 5 edges. Expect `err_code` = 2 at 400 cycles after the first edge.
- BFM leaves data high at the ACK edge. Expect `err_code` = 3 with no `done`.
- Assert `reset` during SEND, and pulse `cmd_valid` while busy. Expect oe = 0 immediately, IDLE, no pulses, and the busy-time request not sent.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host-to-device transmitter.
// Timing defaults assume a 50 MHz CLOCK_50.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_RELEASE,
    ST_WAIT_FIRST,
    ST_SEND,
    ST_ACK,
    ST_WAIT_IDLE
  } ps2_state_t;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_START = 2'd1;
  localparam logic [1:0] ERR_XFER  = 2'd2;
  localparam logic [1:0] ERR_NOACK = 2'd3;

  localparam int DEF_INHIBIT_CYCLES       = 6000;
  localparam int DEF_START_TIMEOUT_CYCLES = 750000;
  localparam int DEF_XFER_TIMEOUT_CYCLES  = 100000;
  localparam int DEF_FILTER_CYCLES        = 4;

  // Data bits, parity and stop; the start bit is driven separately.
  localparam int FRAME_BITS = 10;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronizes one raw PS/2 pin, debounces it and flags 1->0 transitions
// of the accepted level as a one-cycle pulse.
module ps2_line_filter
  import ps2_pkg::*;
#(
  parameter int FILTER_CYCLES = DEF_FILTER_CYCLES
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic pin,
  output logic level,
  output logic fall
);

  localparam int CNT_W = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

  logic             sync1_reg;
  logic             sync2_reg;
  logic             level_reg;
  logic             fall_reg;
  logic [CNT_W-1:0] cnt_reg;

  // Idle bus is high, so everything resets to 1 to avoid a spurious edge.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
      level_reg <= 1'b1;
      fall_reg  <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      sync1_reg <= pin;
      sync2_reg <= sync1_reg;
      fall_reg  <= 1'b0;
      if (sync2_reg != level_reg) begin
        if (cnt_reg == CNT_LAST) begin
          level_reg <= sync2_reg;
          fall_reg  <= ~sync2_reg;
          cnt_reg   <= '0;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end else begin
        cnt_reg <= '0;
      end
    end
  end

  assign level = level_reg;
  assign fall  = fall_reg;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibits the bus, issues a start
// bit, clocks out data/parity/stop on device edges and checks the ACK.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES       = DEF_INHIBIT_CYCLES,
  parameter int START_TIMEOUT_CYCLES = DEF_START_TIMEOUT_CYCLES,
  parameter int XFER_TIMEOUT_CYCLES  = DEF_XFER_TIMEOUT_CYCLES,
  parameter int FILTER_CYCLES        = DEF_FILTER_CYCLES
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] cmd_data,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       done,
  output logic       error,
  output logic [1:0] err_code,
  output logic       rx_inhibit
);

  localparam int TIMER_MAX = max_int(INHIBIT_CYCLES,
                                     max_int(START_TIMEOUT_CYCLES, XFER_TIMEOUT_CYCLES));
  localparam int TIMER_W   = $clog2(TIMER_MAX + 1);

  localparam logic [TIMER_W-1:0] TIMER_TOP    = TIMER_W'(TIMER_MAX);
  localparam logic [TIMER_W-1:0] INHIBIT_LAST = TIMER_W'(INHIBIT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] START_LAST   = TIMER_W'(START_TIMEOUT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] XFER_LAST    = TIMER_W'(XFER_TIMEOUT_CYCLES - 1);
  localparam logic [3:0]         STOP_CNT     = 4'(FRAME_BITS - 1);

  logic clk_level;
  logic clk_fall;
  logic dat_level;
  logic dat_fall_unused;  // only the clock line's edges drive the FSM

  ps2_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_clk_filter (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .pin      (ps2_clk_in),
    .level    (clk_level),
    .fall     (clk_fall)
  );

  ps2_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_dat_filter (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .pin      (ps2_dat_in),
    .level    (dat_level),
    .fall     (dat_fall_unused)
  );

  ps2_state_t                 state_reg, state_next;
  logic [FRAME_BITS-1:0]      shift_reg, shift_next;
  logic [3:0]                 bit_cnt_reg, bit_cnt_next;
  logic [TIMER_W-1:0]         timer_reg, timer_next;
  logic                       clk_oe_reg, clk_oe_next;
  logic                       dat_oe_reg, dat_oe_next;
  logic                       done_reg, done_next;
  logic                       error_reg, error_next;
  logic [1:0]                 err_code_reg, err_code_next;
  logic                       cmd_ready_reg, cmd_ready_next;
  logic                       rx_inhibit_reg, rx_inhibit_next;
  logic                       fail;
  logic [1:0]                 fail_code;

  always_comb begin
    state_next    = state_reg;
    shift_next    = shift_reg;
    bit_cnt_next  = bit_cnt_reg;
    timer_next    = (timer_reg != TIMER_TOP) ? timer_reg + 1'b1 : timer_reg;
    clk_oe_next   = clk_oe_reg;
    dat_oe_next   = dat_oe_reg;
    done_next     = 1'b0;
    error_next    = 1'b0;
    err_code_next = err_code_reg;
    fail          = 1'b0;
    fail_code     = ERR_NONE;

    case (state_reg)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_reg) begin
          shift_next    = {1'b1, ~^cmd_data, cmd_data};
          err_code_next = ERR_NONE;
          timer_next    = TIMER_W'(1);  // counts the first inhibit cycle
          clk_oe_next   = 1'b1;
          state_next    = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        if (timer_reg == INHIBIT_LAST) begin
          dat_oe_next = 1'b1;
          state_next  = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        clk_oe_next = 1'b0;
        timer_next  = '0;
        state_next  = ST_WAIT_FIRST;
      end
      ST_WAIT_FIRST: begin
        if (timer_reg >= START_LAST) begin
          fail      = 1'b1;
          fail_code = ERR_START;
        end else if (clk_fall) begin
          dat_oe_next  = ~shift_reg[0];
          shift_next   = {1'b0, shift_reg[FRAME_BITS-1:1]};
          bit_cnt_next = 4'd1;
          timer_next   = '0;
          state_next   = ST_SEND;
        end
      end
      ST_SEND: begin
        if (timer_reg >= XFER_LAST) begin
          fail      = 1'b1;
          fail_code = ERR_XFER;
        end else if (clk_fall) begin
          bit_cnt_next = bit_cnt_reg + 4'd1;
          if (bit_cnt_reg == STOP_CNT) begin
            dat_oe_next = 1'b0;
            state_next  = ST_ACK;
          end else begin
            dat_oe_next = ~shift_reg[0];
            shift_next  = {1'b0, shift_reg[FRAME_BITS-1:1]};
          end
        end
      end
      ST_ACK: begin
        if (timer_reg >= XFER_LAST) begin
          fail      = 1'b1;
          fail_code = ERR_XFER;
        end else if (clk_fall) begin
          if (!dat_level) begin
            state_next = ST_WAIT_IDLE;
          end else begin
            fail      = 1'b1;
            fail_code = ERR_NOACK;
          end
        end
      end
      ST_WAIT_IDLE: begin
        if (timer_reg >= XFER_LAST) begin
          fail      = 1'b1;
          fail_code = ERR_XFER;
        end else if (clk_level && dat_level) begin
          done_next  = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    if (fail) begin
      clk_oe_next   = 1'b0;
      dat_oe_next   = 1'b0;
      error_next    = 1'b1;
      err_code_next = fail_code;
      state_next    = ST_IDLE;
    end

    cmd_ready_next  = (state_next == ST_IDLE);
    rx_inhibit_next = (state_next != ST_IDLE);
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      shift_reg      <= '0;
      bit_cnt_reg    <= '0;
      timer_reg      <= '0;
      clk_oe_reg     <= 1'b0;
      dat_oe_reg     <= 1'b0;
      done_reg       <= 1'b0;
      error_reg      <= 1'b0;
      err_code_reg   <= ERR_NONE;
      cmd_ready_reg  <= 1'b1;
      rx_inhibit_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      shift_reg      <= shift_next;
      bit_cnt_reg    <= bit_cnt_next;
      timer_reg      <= timer_next;
      clk_oe_reg     <= clk_oe_next;
      dat_oe_reg     <= dat_oe_next;
      done_reg       <= done_next;
      error_reg      <= error_next;
      err_code_reg   <= err_code_next;
      cmd_ready_reg  <= cmd_ready_next;
      rx_inhibit_reg <= rx_inhibit_next;
    end
  end

  assign ps2_clk_oe = clk_oe_reg;
  assign ps2_dat_oe = dat_oe_reg;
  assign done       = done_reg;
  assign error      = error_reg;
  assign err_code   = err_code_reg;
  assign cmd_ready  = cmd_ready_reg;
  assign rx_inhibit = rx_inhibit_reg;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a keyboard-side BFM clocks frames out of the host
// and the captured line activity is compared with a frame model.
module tb_ps2_host_tx;

  localparam int INH = 20;
  localparam int STO = 200;
  localparam int XTO = 400;
  localparam int FLT = 2;

  logic       CLOCK_50 = 1'b0;
  logic       reset    = 1'b1;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       ps2_clk_in, ps2_dat_in;
  logic       ps2_clk_oe, ps2_dat_oe;
  logic       done, error;
  logic [1:0] err_code;
  logic       rx_inhibit;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;

  // Open-drain bus: either side can pull a line low.
  assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
  assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES       (INH),
    .START_TIMEOUT_CYCLES (STO),
    .XFER_TIMEOUT_CYCLES  (XTO),
    .FILTER_CYCLES        (FLT)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .cmd_data   (cmd_data),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .ps2_clk_in (ps2_clk_in),
    .ps2_dat_in (ps2_dat_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe),
    .done       (done),
    .error      (error),
    .err_code   (err_code),
    .rx_inhibit (rx_inhibit)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Event monitor, sampled mid-cycle.
  int done_cnt = 0, err_cnt = 0, both_cnt = 0, error_cyc = 0;
  int clk_rise_cyc = 0, clk_fall_cyc = 0, dat_rise_cyc = 0, dat_fall_cyc = 0;
  int clk_rise_cnt = 0;
  logic prev_clk_oe = 1'b0, prev_dat_oe = 1'b0;
  bit got_dat_rise = 0, got_dat_fall = 0;

  always @(negedge CLOCK_50) begin
    if (done) done_cnt++;
    if (error) begin
      err_cnt++;
      error_cyc = cyc;
    end
    if (done && error) both_cnt++;
    if (ps2_clk_oe && !prev_clk_oe) begin
      clk_rise_cyc = cyc;
      clk_rise_cnt++;
      got_dat_rise = 0;
      got_dat_fall = 0;
    end
    if (!ps2_clk_oe && prev_clk_oe) clk_fall_cyc = cyc;
    if (ps2_clk_oe && ps2_dat_oe && !prev_dat_oe && !got_dat_rise) begin
      dat_rise_cyc = cyc;
      got_dat_rise = 1;
    end
    if (!ps2_clk_oe && !ps2_dat_oe && prev_dat_oe && !got_dat_fall) begin
      dat_fall_cyc = cyc;
      got_dat_fall = 1;
    end
    prev_clk_oe = ps2_clk_oe;
    prev_dat_oe = ps2_dat_oe;
  end

  // Expected data-line drive seen during each device clock-low phase:
  // 8 data bits LSB first, odd parity, then stop and ACK phases released.
  function automatic logic [10:0] model_oe(input logic [7:0] b);
    logic [10:0] r;
    bit par;
    par = (($countones(b) % 2) == 0);
    r = '0;
    for (int i = 0; i < 8; i++) r[i] = !b[i];
    r[8] = !par;
    return r;
  endfunction

  task automatic send(input logic [7:0] b, output int p);
    @(posedge CLOCK_50); #1;
    cmd_data  = b;
    cmd_valid = 1'b1;
    @(posedge CLOCK_50); #1;
    p = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_release(output bit ok);
    ok = 0;
    for (int i = 0; i < INH + 20 && !ok; i++) begin
      @(posedge CLOCK_50); #1;
      if (!ps2_clk_oe) ok = 1;
    end
  endtask

  task automatic device(input int n_edges, input bit ack_low, input int half,
                        output logic [10:0] cap);
    cap = '0;
    repeat (5) @(posedge CLOCK_50);
    for (int i = 0; i < n_edges; i++) begin
      #1;
      if (i == 10 && ack_low) dev_dat = 1'b0;
      repeat (half) @(posedge CLOCK_50);
      #1 dev_clk = 1'b0;
      repeat (half) @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      cap[i] = ps2_dat_oe;
      @(posedge CLOCK_50);
      #1 dev_clk = 1'b1;
      if (i == 10) dev_dat = 1'b1;
    end
  endtask

  task automatic wait_pulse(input int budget, input int s_done, input int s_err, output bit ok);
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge CLOCK_50); #1;
      if (done_cnt != s_done || err_cnt != s_err) ok = 1;
    end
    @(posedge CLOCK_50); #1;
  endtask

  int txn_no = 0;

  task automatic run_txn(input logic [7:0] b, input int half, input bit ack_low);
    int p, s_done, s_err;
    bit ok;
    logic [10:0] cap;
    s_done = done_cnt;
    s_err  = err_cnt;
    send(b, p);
    wait_release(ok);
    chk("release", 32'(ok), 1);
    chk("start_bit", 32'(ps2_dat_oe), 1);
    device(11, ack_low, half, cap);
    wait_pulse(200, s_done, s_err, ok);
    chk("pulse_seen", 32'(ok), 1);
    chk("clk_oe_rise", clk_rise_cyc - p, 0);
    chk("dat_oe_rise", dat_rise_cyc - p, INH - 1);
    chk("clk_oe_fall", clk_fall_cyc - p, INH);
    chk("frame", 32'(cap), 32'(model_oe(b)));
    chk("done_cnt", done_cnt - s_done, ack_low ? 1 : 0);
    chk("error_cnt", err_cnt - s_err, ack_low ? 0 : 1);
    chk("err_code", 32'(err_code), ack_low ? 0 : 3);
    chk("oe_idle", 32'({ps2_clk_oe, ps2_dat_oe}), 0);
    chk("ready_idle", 32'({cmd_ready, rx_inhibit}), 32'b10);
    $display("txn %0d: cmd=%02h half=%0d ack=%0d frame=%03h done=%0d err_code=%0d",
             txn_no, b, half, ack_low, cap, done_cnt - s_done, err_code);
    txn_no++;
  endtask

  initial begin
    int p, s_done, s_err, rise_before;
    bit ok;
    logic [10:0] cap;

    repeat (3) @(posedge CLOCK_50);
    #1;
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    chk("rst_oe", 32'({ps2_clk_oe, ps2_dat_oe}), 0);
    chk("rst_pulses", 32'({done, error}), 0);
    chk("rst_err_code", 32'(err_code), 0);
    chk("rst_rx_inhibit", 32'(rx_inhibit), 0);
    reset = 1'b0;
    repeat (5) @(posedge CLOCK_50);

    // Directed frames from the command set.
    run_txn(8'hED, 8, 1'b1);
    run_txn(8'hF4, 8, 1'b1);
    run_txn(8'hA5, 7, 1'b0);

    // Randomized frames, occasionally without ACK.
    for (int k = 0; k < 8; k++) begin
      run_txn(8'($urandom), $urandom_range(6, 12), ($urandom_range(0, 3) != 0));
    end

    // Device never clocks.
    s_done = done_cnt;
    s_err  = err_cnt;
    send(8'hF4, p);
    wait_release(ok);
    chk("st_release", 32'(ok), 1);
    wait_pulse(STO + 50, s_done, s_err, ok);
    chk("st_pulse_seen", 32'(ok), 1);
    chk("st_latency", error_cyc - clk_fall_cyc, STO);
    chk("st_err_code", 32'(err_code), 1);
    chk("st_done", done_cnt - s_done, 0);
    chk("st_oe", 32'({ps2_clk_oe, ps2_dat_oe}), 0);
    $display("txn %0d: cmd=f4 no device clock err_code=%0d", txn_no, err_code);
    txn_no++;

    // Device stops after five edges.
    s_done = done_cnt;
    s_err  = err_cnt;
    send(8'hED, p);
    wait_release(ok);
    chk("xt_release", 32'(ok), 1);
    device(5, 1'b0, 8, cap);
    wait_pulse(XTO + 100, s_done, s_err, ok);
    chk("xt_pulse_seen", 32'(ok), 1);
    chk("xt_latency", error_cyc - dat_fall_cyc, XTO);
    chk("xt_err_code", 32'(err_code), 2);
    chk("xt_done", done_cnt - s_done, 0);
    chk("xt_oe", 32'({ps2_clk_oe, ps2_dat_oe}), 0);
    $display("txn %0d: cmd=ed device stalls after 5 edges err_code=%0d", txn_no, err_code);
    txn_no++;

    // Reset in the middle of SEND, with a request made while busy.
    s_done = done_cnt;
    s_err  = err_cnt;
    send(8'h00, p);
    wait_release(ok);
    chk("rs_release", 32'(ok), 1);
    device(3, 1'b0, 8, cap);
    @(posedge CLOCK_50); #1;
    cmd_data  = 8'h3C;
    cmd_valid = 1'b1;
    @(posedge CLOCK_50); #1;
    chk("busy_ready", 32'(cmd_ready), 0);
    cmd_valid = 1'b0;
    rise_before = clk_rise_cnt;
    @(negedge CLOCK_50);
    chk("pre_rst_dat_oe", 32'(ps2_dat_oe), 1);
    #2 reset = 1'b1;
    #1;
    chk("rs_clk_oe", 32'(ps2_clk_oe), 0);
    chk("rs_dat_oe", 32'(ps2_dat_oe), 0);
    chk("rs_ready", 32'({cmd_ready, rx_inhibit}), 32'b10);
    repeat (3) @(posedge CLOCK_50);
    #1 reset = 1'b0;
    repeat (60) @(posedge CLOCK_50);
    #1;
    chk("rs_no_resend", clk_rise_cnt - rise_before, 0);
    chk("rs_no_done", done_cnt - s_done, 0);
    chk("rs_no_error", err_cnt - s_err, 0);
    chk("rs_idle", 32'({cmd_ready, ps2_clk_oe, ps2_dat_oe}), 32'b100);
    $display("txn %0d: cmd=00 reset during send, busy request 3c dropped", txn_no);
    txn_no++;

    // Recovery after reset.
    run_txn(8'hFF, 9, 1'b1);

    chk("done_error_exclusive", both_cnt, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #(20 * 60000);
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule
